// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serialises two requesters onto a single-port memory.
// Read data and read-timeout errors are routed back to the port that issued the read.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rerr0,
  output logic              rerr1,
  output logic              renable,
  output logic              wenable,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              valid_out,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        rerr_q, rerr_d;
  logic [1:0]        gnt;
  logic              pick;

  // On a tie the port that was not granted last wins.
  assign pick = (req0 && req1) ? ~last_gnt_q : req1;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = '0;
    rerr_d     = '0;
    gnt        = '0;
    renable    = 1'b0;
    wenable    = 1'b0;
    addr       = '0;
    data_in    = '0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          win_d   = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        gnt[win_q] = 1'b1;
        addr       = addr_q;
        last_gnt_d = win_q;
        if (we_q) begin
          wenable = 1'b1;
          data_in = wdata_q;
          state_d = StIdle;
        end else begin
          renable = 1'b1;
          cnt_d   = '0;
          state_d = StWaitRd;
        end
      end
      StWaitRd: begin
        if (valid_out) begin
          rdata_d         = data_out;
          rvalid_d[win_q] = 1'b1;
          state_d         = StIdle;
        end else if (cnt_q == CntW'(RD_TIMEOUT - 1)) begin
          // Last waiting cycle without data: report the timeout next cycle.
          rerr_d[win_q] = 1'b1;
          state_d       = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      rvalid_q   <= '0;
      rerr_q     <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
    end
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid_q[0];
  assign rvalid1 = rvalid_q[1];
  assign rerr0   = rerr_q[0];
  assign rerr1   = rerr_q[1];
  assign rdata0  = rvalid_q[0] ? rdata_q : '0;
  assign rdata1  = rvalid_q[1] ? rdata_q : '0;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a stand-in memory, a transaction-level
// reference model of arbitration order and memory contents, and a decoupled monitor.
module tb_mem_port_arbiter;

  localparam int unsigned RdTimeout = 4;

  logic        clk, rst;
  logic        req0, we0, req1, we1;
  logic [3:0]  addr0, addr1, addr;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, data_in, data_out;
  logic        gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
  logic        renable, wenable, valid_out, busy;

  mem_port_arbiter #(
    .ADDR_W    (4),
    .DATA_W    (32),
    .RD_TIMEOUT(RdTimeout)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rdata0   (rdata0),
    .rdata1   (rdata1),
    .rvalid0  (rvalid0),
    .rvalid1  (rvalid1),
    .rerr0    (rerr0),
    .rerr1    (rerr1),
    .renable  (renable),
    .wenable  (wenable),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .busy     (busy)
  );

  typedef struct packed {
    logic        port;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q0[$];
  rsp_t        rsp_q1[$];
  logic [31:0] ref_mem [16];
  logic        m_last;
  int          checks, errors, cyc;
  int          gnt_cyc [2];

  // Memory stand-in: 1-cycle read latency, optional dropped/forced/spurious valid_out.
  logic [31:0] mem [16];
  bit          mem_drop, spur_en, force_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    valid_out <= 1'b0;
    if (renable && !mem_drop) begin
      data_out  <= mem[addr];
      valid_out <= 1'b1;
    end else if (force_valid) begin
      data_out  <= 32'hBAD0_0001;
      valid_out <= 1'b1;
    end else if (spur_en && !mem_drop && $urandom_range(0, 3) == 0) begin
      data_out  <= $urandom;
      valid_out <= 1'b1;
    end
    if (wenable) mem[addr] <= data_in;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one call per transaction, in the order the arbiter must serve them.
  task automatic model_issue(input int p, input logic w, input logic [3:0] a,
                             input logic [31:0] d, input bit drop);
    iss_t e;
    rsp_t r;
    e.port  = p[0];
    e.we    = w;
    e.addr  = a;
    e.wdata = d;
    iss_q.push_back(e);
    if (w) begin
      ref_mem[a] = d;
    end else begin
      r.err  = drop;
      r.data = drop ? 32'h0 : ref_mem[a];
      if (p == 0) rsp_q0.push_back(r);
      else        rsp_q1.push_back(r);
    end
    m_last = p[0];
  endtask

  task automatic mon_port(input int p, input logic rv, input logic re, input logic [31:0] rd);
    rsp_t r;
    bit   empty;
    if (rv || re) begin
      chk("rvalid_rerr_exclusive", rv & re, 0);
      empty = (p == 0) ? (rsp_q0.size() == 0) : (rsp_q1.size() == 0);
      if (empty) begin
        chk($sformatf("unexpected_resp_port%0d", p), {rv, re}, 0);
      end else begin
        if (p == 0) r = rsp_q0.pop_front();
        else        r = rsp_q1.pop_front();
        chk($sformatf("resp_is_err_port%0d", p), re, r.err);
        if (rv) chk($sformatf("rdata_port%0d", p), rd, r.data);
        chk("resp_latency", cyc - gnt_cyc[p], r.err ? 1 + RdTimeout : 2);
        chk("busy_at_resp", busy, 0);
      end
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard on every falling edge.
  initial begin
    iss_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc++;
        chk("gnt_exclusive", gnt0 & gnt1, 0);
        chk("strobe_exclusive", renable & wenable, 0);
        if (gnt0 || gnt1) begin
          if (iss_q.size() == 0) begin
            chk("unexpected_gnt", {gnt1, gnt0}, 0);
          end else begin
            e = iss_q.pop_front();
            chk("gnt_port", gnt1, e.port);
            chk("wenable", wenable, e.we);
            chk("renable", renable, !e.we);
            chk("addr", addr, e.addr);
            chk("data_in", data_in, e.we ? e.wdata : 32'h0);
            if (!e.we) gnt_cyc[e.port] = cyc;
          end
        end else begin
          chk("idle_bus", {renable, wenable, addr, data_in}, 0);
        end
        mon_port(0, rvalid0, rerr0, rdata0);
        mon_port(1, rvalid1, rerr1, rdata1);
      end
    end
  end

  // pat: 0 = port 0 only, 1 = port 1 only, 2 = both together.
  task automatic round(input int pat, input logic w0, input logic [3:0] a0,
                       input logic [31:0] d0, input logic w1, input logic [3:0] a1,
                       input logic [31:0] d1, input bit drop);
    int first, lat, left;
    bit pend0, pend1;
    first = (pat == 2) ? ((m_last == 1'b0) ? 1 : 0) : pat;
    model_issue(first, first ? w1 : w0, first ? a1 : a0, first ? d1 : d0, drop);
    if (pat == 2) model_issue(1 - first, first ? w0 : w1, first ? a0 : a1, first ? d0 : d1, drop);
    mem_drop = drop;
    spur_en  = !drop;
    pend0  = (pat != 1);
    pend1  = (pat != 0);
    req0   = pend0;
    we0    = w0;
    addr0  = a0;
    wdata0 = d0;
    req1   = pend1;
    we1    = w1;
    addr1  = a1;
    wdata1 = d1;
    lat    = 0;
    for (int n = 1; n <= 40 && (pend0 || pend1); n++) begin
      @(negedge clk);
      if ((gnt0 || gnt1) && lat == 0) lat = n;
      if (gnt0 && pend0) begin
        pend0 = 1'b0;
        req0  = 1'b0;
      end
      if (gnt1 && pend1) begin
        pend1 = 1'b0;
        req1  = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("grant_timeout", {pend1, pend0}, 0);
    chk("first_gnt_latency", lat, 1);
    for (int n = 0; n < 40 && (iss_q.size() + rsp_q0.size() + rsp_q1.size()) != 0; n++)
      @(negedge clk);
    left = iss_q.size() + rsp_q0.size() + rsp_q1.size();
    chk("drain_timeout", left, 0);
    if (left != 0) begin
      iss_q.delete();
      rsp_q0.delete();
      rsp_q1.delete();
    end
    @(negedge clk);
    mem_drop = 1'b0;
  endtask

  task automatic reset_mid_read();
    iss_t e;
    bit   seen;
    spur_en  = 1'b0;
    mem_drop = 1'b1;
    e.port   = 1'b0;
    e.we     = 1'b0;
    e.addr   = 4'h3;
    e.wdata  = 32'h0;
    iss_q.push_back(e);
    m_last = 1'b0;
    req0   = 1'b1;
    we0    = 1'b0;
    addr0  = 4'h3;
    seen   = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = gnt0;
    end
    req0 = 1'b0;
    chk("mid_reset_gnt_seen", seen, 1);
    @(negedge clk);
    chk("busy_in_wait_rd", busy, 1);
    rst    = 1'b0;
    m_last = 1'b1;
    rsp_q0.delete();
    rsp_q1.delete();
    @(negedge clk);
    chk("reset_mid_busy", busy, 0);
    chk("reset_mid_outputs", {gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, renable, wenable}, 0);
    rst         = 1'b1;
    mem_drop    = 1'b0;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("post_reset_quiet", {busy, rvalid0, rerr0, rvalid1, rerr1}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    gnt_cyc[0] = 0;
    gnt_cyc[1] = 0;
    m_last = 1'b1;
    mem_drop = 1'b0;
    spur_en = 1'b0;
    force_valid = 1'b0;
    rst = 1'b0;
    {req0, we0, req1, we1} = '0;
    {addr0, addr1} = '0;
    {wdata0, wdata1} = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_strobes", {renable, wenable}, 0);
    chk("reset_bus", {addr, data_in}, 0);
    chk("reset_handshake", {gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1}, 0);
    chk("reset_rdata", {rdata0, rdata1}, 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_reset", {busy, gnt0, gnt1}, 0);
    end

    // Directed: write/read port 0, routed read on port 1, alternation, timeout.
    round(0, 1'b1, 4'h3, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 1'b0);
    round(0, 1'b0, 4'h3, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    round(1, 1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h12345678, 1'b0);
    round(2, 1'b1, 4'h5, 32'hA5A5A5A5, 1'b0, 4'hF, 32'h0, 1'b0);
    round(2, 1'b1, 4'h6, 32'h11111111, 1'b1, 4'h7, 32'h22222222, 1'b0);
    round(2, 1'b1, 4'h8, 32'h33333333, 1'b1, 4'h9, 32'h44444444, 1'b0);
    round(0, 1'b0, 4'h3, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1);
    round(0, 1'b1, 4'h4, 32'h55555555, 1'b0, 4'h0, 32'h0, 1'b0);
    reset_mid_read();
    round(2, 1'b0, 4'h3, 32'h0, 1'b0, 4'hF, 32'h0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      round(int'($urandom_range(0, 1)), 1'b1, a[3:0], $urandom, 1'b1, a[3:0], $urandom, 1'b0);
    end

    for (int i = 0; i < 150; i++) begin
      round(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
            $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
